// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - boot-time sequencer for instruction memory clear and program load
// Holds the CPU in reset, clears the memory, then streams program words into it from address 0.
module imem_boot_loader #(
   parameter int DEPTH        = 256,
   parameter int CLEAR_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        load_valid,
   input  logic [31:0] load_data,
   input  logic        load_last,
   output logic        load_ready,
   output logic        instruction_reset,
   output logic        write_signal,
   output logic [31:0] instruction_write,
   output logic [31:0] write_address,
   output logic        cpu_reset,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [8:0]  words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [8:0] DEPTH_W    = 9'(DEPTH);
   localparam logic [3:0] CLEAR_LAST = 4'(CLEAR_CYCLES - 1);

   state_t     state;
   logic [3:0] clear_cnt;
   logic       accept;

   // load_ready comes straight from the state so it never combinationally depends on load_valid
   assign load_ready = (state == S_LOAD);
   assign accept     = load_valid && load_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= S_IDLE;
         clear_cnt         <= 4'd0;
         words_loaded      <= 9'd0;
         instruction_reset <= 1'b0;
         write_signal      <= 1'b0;
         instruction_write <= 32'd0;
         write_address     <= 32'd0;
         cpu_reset         <= 1'b1;
         busy              <= 1'b0;
         done              <= 1'b0;
         error             <= 1'b0;
      end else begin
         write_signal <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state             <= S_CLEAR;
                  clear_cnt         <= 4'd0;
                  instruction_reset <= 1'b1;
                  cpu_reset         <= 1'b1;
                  busy              <= 1'b1;
                  done              <= 1'b0;
                  error             <= 1'b0;
               end
            end

            S_CLEAR: begin
               if (clear_cnt == CLEAR_LAST) begin
                  state             <= S_LOAD;
                  instruction_reset <= 1'b0;
                  words_loaded      <= 9'd0;
               end else begin
                  clear_cnt <= clear_cnt + 4'd1;
               end
            end

            S_LOAD: begin
               if (accept) begin
                  if (words_loaded < DEPTH_W) begin
                     write_signal      <= 1'b1;
                     instruction_write <= load_data;
                     write_address     <= {23'd0, words_loaded};
                     words_loaded      <= words_loaded + 9'd1;
                     if (load_last) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                     end
                  end else begin
                     // memory already full: drop the beat and flag overflow
                     state <= S_ERROR;
                     busy  <= 1'b0;
                     error <= 1'b1;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
